// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle ARM controller: FSM states, ALU codes,
// instruction fields, condition codes and datapath select values.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_RD1    = 2'b00;
    localparam logic [1:0] SRCA_PC     = 2'b01;
    localparam logic [1:0] SRCA_ALUOUT = 2'b10;

    localparam logic [1:0] SRCB_RM   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    // ARM condition evaluation; flags are packed {C,V,N,Z}
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] flags);
        logic c, v, n, z;
        logic res;
        {c, v, n, z} = flags;
        case (cond)
            4'b0000: res = z;
            4'b0001: res = ~z;
            4'b0010: res = c;
            4'b0011: res = ~c;
            4'b0100: res = n;
            4'b0101: res = ~n;
            4'b0110: res = v;
            4'b0111: res = ~v;
            4'b1000: res = c & ~z;
            4'b1001: res = ~c | z;
            4'b1010: res = (n == v);
            4'b1011: res = (n != v);
            4'b1100: res = ~z & (n == v);
            4'b1101: res = z | (n != v);
            4'b1110: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and ALU flags in,
// every enable/select out. The controller uses the slave modport.
interface multicycle_controller_if #(parameter int ALUCTL_W = 2);

    logic [3:0]          Cond;
    logic [1:0]          Op;
    logic [5:0]          Funct;
    logic [3:0]          Rd;
    logic [3:0]          ALUFlags;
    logic                PCWrite;
    logic                AdrSrc;
    logic                MemWrite;
    logic                IRWrite;
    logic                RegWrite;
    logic [1:0]          ResultSrc;
    logic [1:0]          ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic [1:0]          ImmSrc;
    logic [1:0]          RegSrc;
    logic [ALUCTL_W-1:0] ALUControl;
    logic                C_In;

    modport master (
        output Cond, Op, Funct, Rd, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, C_In
    );

    modport slave (
        input  Cond, Op, Funct, Rd, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, C_In
    );

endinterface

// File: rtl/mc_cond_unit.sv
// Condition unit: NZCV register with independent {C,V}/{N,Z} write enables,
// and a per-instruction CondEx latched in DECODE so that flags written at the
// end of execute cannot change the verdict for the write-back cycle.
module mc_cond_unit
    import mc_ctrl_pkg::*;
#(
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic       cond_latch,
    input  logic [1:0] flag_w,
    output logic       cond_ex,
    output logic       c_in
);

    logic [3:0] flags_reg;
    logic       cond_ex_reg;

    // flag register: bit1 of flag_w enables {C,V}, bit0 enables {N,Z}
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_reg <= FLAG_RST;
        end else begin
            if (flag_w[1] && cond_ex_reg) flags_reg[3:2] <= alu_flags[3:2];
            if (flag_w[0] && cond_ex_reg) flags_reg[1:0] <= alu_flags[1:0];
        end
    end

    // capture the condition verdict once per instruction, while flags are stable
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cond_ex_reg <= 1'b0;
        end else if (cond_latch) begin
            cond_ex_reg <= cond_check(cond, flags_reg);
        end
    end

    assign cond_ex = cond_ex_reg;
    assign c_in    = flags_reg[3];

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle ARM control unit: Moore FSM sequencing fetch/decode/execute,
// instruction decoder for datapath selects, and the embedded condition unit.
module multicycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int         ALUCTL_W = 2,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.slave bus
);

    state_t     state_reg, state_next;
    logic [3:0] cmd;
    logic       i_bit, s_bit;
    logic [1:0] dp_alu_ctl;
    logic [1:0] dp_flag_w;
    logic       dp_no_write;
    logic       rd_is_pc;
    logic [1:0] flag_w;
    logic       cond_latch;
    logic       cond_ex;
    logic       c_in;

    mc_cond_unit #(.FLAG_RST(FLAG_RST)) u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (bus.Cond),
        .alu_flags  (bus.ALUFlags),
        .cond_latch (cond_latch),
        .flag_w     (flag_w),
        .cond_ex    (cond_ex),
        .c_in       (c_in)
    );

    // instruction decoder: ALU op, flag-write class and write suppression for DP
    always_comb begin
        cmd         = bus.Funct[4:1];
        i_bit       = bus.Funct[5];
        s_bit       = bus.Funct[0];
        rd_is_pc    = (bus.Rd == 4'hF);
        dp_alu_ctl  = ALU_ADD;
        dp_flag_w   = 2'b00;
        dp_no_write = 1'b0;
        case (cmd)
            CMD_ADD: begin dp_alu_ctl = ALU_ADD; dp_flag_w = {s_bit, s_bit}; end
            CMD_SUB: begin dp_alu_ctl = ALU_SUB; dp_flag_w = {s_bit, s_bit}; end
            CMD_AND: begin dp_alu_ctl = ALU_AND; dp_flag_w = {1'b0, s_bit}; end
            CMD_ORR: begin dp_alu_ctl = ALU_ORR; dp_flag_w = {1'b0, s_bit}; end
            CMD_CMP: begin dp_alu_ctl = ALU_SUB; dp_flag_w = 2'b11; dp_no_write = 1'b1; end
            default: begin dp_alu_ctl = ALU_ADD; dp_flag_w = 2'b00; dp_no_write = 1'b1; end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_reg <= S_FETCH;
        else        state_reg <= state_next;
    end

    // next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (bus.Op)
                    OP_MEM:  state_next = S_MEMADR;
                    OP_DP:   state_next = i_bit ? S_EXECI : S_EXECR;
                    OP_B:    state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = bus.Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_next = S_ALUWB;
            default:  state_next = S_FETCH;
        endcase
    end

    // Moore output decode; writes that commit architectural state are gated by cond_ex
    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ResultSrc  = RES_ALUOUT;
        bus.ALUSrcA    = SRCA_RD1;
        bus.ALUSrcB    = SRCB_RM;
        bus.ALUControl = ALUCTL_W'(ALU_ADD);
        bus.ImmSrc     = (bus.Op == OP_MEM) ? IMM_MEM : (bus.Op == OP_B) ? IMM_BR : IMM_DP;
        bus.RegSrc     = {(bus.Op == OP_MEM) && !bus.Funct[0], bus.Op == OP_B};
        bus.C_In       = c_in;
        flag_w         = 2'b00;
        cond_latch     = 1'b0;
        case (state_reg)
            S_FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.PCWrite   = 1'b1;
                bus.ALUSrcA   = SRCA_PC;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                bus.ALUSrcA = SRCA_PC;
                bus.ALUSrcB = SRCB_FOUR;
                cond_latch  = 1'b1;
            end
            S_MEMADR: bus.ALUSrcB = SRCB_IMM;
            S_MEMRD:  bus.AdrSrc  = 1'b1;
            S_MEMWB: begin
                bus.AdrSrc    = 1'b1;
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = cond_ex && !rd_is_pc;
            end
            S_MEMWR: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = cond_ex;
            end
            S_EXECR, S_EXECI: begin
                bus.ALUSrcB    = (state_reg == S_EXECI) ? SRCB_IMM : SRCB_RM;
                bus.ALUControl = ALUCTL_W'(dp_alu_ctl);
                flag_w         = dp_flag_w;
            end
            S_ALUWB:  bus.RegWrite = cond_ex && !dp_no_write && !rd_is_pc;
            S_BRANCH: begin
                bus.ALUSrcA   = SRCA_ALUOUT;
                bus.ALUSrcB   = SRCB_IMM;
                bus.ResultSrc = RES_ALURESULT;
                bus.PCWrite   = cond_ex;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: stimulus pushes the expected
// control word of every cycle; a negedge monitor pops and compares.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] res, srca, srcb, imm, regsrc, aluc;
        logic       cin;
    } ctrl_t;

    typedef struct {
        ctrl_t c;
        int    id;
        int    cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multicycle_controller_if #(.ALUCTL_W(2)) bus();

    multicycle_controller #(.ALUCTL_W(2), .FLAG_RST(4'b0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         n_instr = 0;
    logic [3:0] flags_m = 4'b0000;   // reference {C,V,N,Z}
    exp_t       q[$];

    // monitor: one expected control word per cycle
    always @(negedge clk) begin
        exp_t  e;
        ctrl_t act;
        if (q.size() > 0) begin
            e = q.pop_front();
            act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                   bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc,
                   bus.ALUControl, bus.C_In};
            checks++;
            if (act !== e.c) begin
                errors++;
                $display("FAIL ctrl instr %0d cycle %0d: got %b required %b", e.id, e.cyc, act, e.c);
            end
        end
    end

    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic c, v, n, z, r;
        c = f[3]; v = f[2]; n = f[1]; z = f[0];
        if (cond == 4'hE) return 1'b1;
        if (cond == 4'hF) return 1'b0;
        case (cond[3:1])
            3'd0:    r = z;
            3'd1:    r = c;
            3'd2:    r = n;
            3'd3:    r = v;
            3'd4:    r = c & ~z;
            3'd5:    r = (n == v);
            default: r = ~z & (n == v);
        endcase
        return cond[0] ? ~r : r;
    endfunction

    function automatic ctrl_t fetch_word(input ctrl_t base);
        ctrl_t c;
        c = base;
        c.pcw = 1'b1; c.irw = 1'b1; c.srca = 2'b01; c.srcb = 2'b10; c.res = 2'b10;
        return c;
    endfunction

    function automatic ctrl_t base_word(input logic [1:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        c.imm    = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
        c.regsrc = {op == 2'b01 && !funct[0], op == 2'b10};
        c.cin    = flags_m[3];
        return c;
    endfunction

    task automatic emit(input ctrl_t c, input logic [3:0] af, input int cyc);
        exp_t e;
        bus.ALUFlags = af;
        e.c = c; e.id = n_instr; e.cyc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] cond, input logic [1:0] op,
                         input logic [5:0] funct, input logic [3:0] rd);
        n_instr++;
        bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.Rd = rd;
        $display("instr %0d cond=%h op=%b funct=%b rd=%0d flags=%b", n_instr, cond, op, funct, rd, flags_m);
    endtask

    task automatic run_instr(input logic [3:0] cond, input logic [1:0] op,
                             input logic [5:0] funct, input logic [3:0] rd,
                             input logic [3:0] exec_af);
        ctrl_t      base, c;
        logic       ce, s, writes;
        logic [3:0] cmd;
        drive(cond, op, funct, rd);
        ce   = cond_holds(cond, flags_m);
        cmd  = funct[4:1];
        s    = funct[0];
        base = base_word(op, funct);
        emit(fetch_word(base), 4'($urandom), 0);
        c = base; c.srca = 2'b01; c.srcb = 2'b10;
        emit(c, 4'($urandom), 1);
        case (op)
            2'b10: begin
                c = base; c.srca = 2'b10; c.srcb = 2'b01; c.res = 2'b10; c.pcw = ce;
                emit(c, 4'($urandom), 2);
            end
            2'b01: begin
                c = base; c.srcb = 2'b01;
                emit(c, 4'($urandom), 2);
                if (funct[0]) begin
                    c = base; c.adr = 1'b1;
                    emit(c, 4'($urandom), 3);
                    c.res = 2'b01; c.regw = ce && (rd != 4'hF);
                    emit(c, 4'($urandom), 4);
                end else begin
                    c = base; c.adr = 1'b1; c.memw = ce;
                    emit(c, 4'($urandom), 3);
                end
            end
            2'b00: begin
                c = base; c.srcb = funct[5] ? 2'b01 : 2'b00;
                case (cmd)
                    4'b0010, 4'b1010: c.aluc = 2'b01;
                    4'b0000:          c.aluc = 2'b10;
                    4'b1100:          c.aluc = 2'b11;
                    default:          c.aluc = 2'b00;
                endcase
                emit(c, exec_af, 2);
                if (ce) begin
                    case (cmd)
                        4'b0100, 4'b0010: if (s) flags_m = exec_af;
                        4'b0000, 4'b1100: if (s) flags_m[1:0] = exec_af[1:0];
                        4'b1010:          flags_m = exec_af;
                        default: ;
                    endcase
                end
                writes = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) || (cmd == 4'b1100);
                c = base; c.cin = flags_m[3]; c.regw = ce && writes && (rd != 4'hF);
                emit(c, 4'($urandom), 3);
            end
            default: ;
        endcase
    endtask

    // DP instruction aborted by reset while in its execute cycle
    task automatic run_abort(input logic [5:0] funct, input logic [3:0] af);
        ctrl_t base, c;
        drive(4'hE, 2'b00, funct, 4'd3);
        base = base_word(2'b00, funct);
        emit(fetch_word(base), 4'($urandom), 0);
        c = base; c.srca = 2'b01; c.srcb = 2'b10;
        emit(c, 4'($urandom), 1);
        reset = 1'b0;
        flags_m = 4'b0000;
        base = base_word(2'b00, funct);
        emit(fetch_word(base), af, 2);
        emit(fetch_word(base), af, 3);
        reset = 1'b1;
    endtask

    function automatic logic [3:0] pick_cmd();
        case ($urandom_range(0, 5))
            0:       return 4'b0100;
            1:       return 4'b0010;
            2:       return 4'b0000;
            3:       return 4'b1100;
            4:       return 4'b1010;
            default: return 4'($urandom);
        endcase
    endfunction

    initial begin
        logic [3:0] cond;
        logic [1:0] op;
        logic [5:0] funct;
        bus.Cond = 4'hE; bus.Op = 2'b00; bus.Funct = 6'd0; bus.Rd = 4'd0; bus.ALUFlags = 4'd0;
        @(posedge clk);
        #1;
        // reset state: FETCH decode with reset flags
        emit(fetch_word(base_word(2'b00, 6'd0)), 4'hF, 0);
        emit(fetch_word(base_word(2'b00, 6'd0)), 4'hF, 0);
        reset = 1'b1;

        // ADDS R1,R2,R3 then branches observing Z=1,V=1
        run_instr(4'hE, 2'b00, 6'b001001, 4'd1, 4'b0101);
        run_instr(4'h0, 2'b10, 6'd0, 4'd0, 4'd0);   // BEQ taken
        run_instr(4'h1, 2'b10, 6'd0, 4'd0, 4'd0);   // BNE not taken
        run_instr(4'h6, 2'b10, 6'd0, 4'd0, 4'd0);   // BVS taken
        run_instr(4'h2, 2'b10, 6'd0, 4'd0, 4'd0);   // BCS not taken
        // LDR / STR
        run_instr(4'hE, 2'b01, 6'b011001, 4'd2, 4'd0);
        run_instr(4'hE, 2'b01, 6'b011000, 4'd2, 4'd0);
        // set C,V then ANDS: only N,Z change
        run_instr(4'hE, 2'b00, 6'b001001, 4'd4, 4'b1100);
        run_instr(4'hE, 2'b00, 6'b000001, 4'd4, 4'b0010);
        run_instr(4'h4, 2'b10, 6'd0, 4'd0, 4'd0);   // BMI taken
        run_instr(4'h2, 2'b10, 6'd0, 4'd0, 4'd0);   // BCS taken
        run_instr(4'h0, 2'b10, 6'd0, 4'd0, 4'd0);   // BEQ not taken
        // CMP sets Z, no register write
        run_instr(4'hE, 2'b00, 6'b010101, 4'd5, 4'b0001);
        run_instr(4'h0, 2'b10, 6'd0, 4'd0, 4'd0);
        // never-execute ADDS and undefined Op leave flags alone
        run_instr(4'hF, 2'b00, 6'b001001, 4'd6, 4'b1110);
        run_instr(4'hE, 2'b11, 6'b001001, 4'd6, 4'b1110);
        run_instr(4'h0, 2'b10, 6'd0, 4'd0, 4'd0);
        // Rd==15 writes suppressed
        run_instr(4'hE, 2'b00, 6'b001000, 4'd15, 4'd0);
        run_instr(4'hE, 2'b01, 6'b011001, 4'd15, 4'd0);
        // reset mid-execute after making flags nonzero
        run_instr(4'hE, 2'b00, 6'b001001, 4'd7, 4'b1111);
        run_abort(6'b001001, 4'b1010);
        run_instr(4'hE, 2'b00, 6'b001000, 4'd7, 4'd0);
        run_instr(4'h2, 2'b10, 6'd0, 4'd0, 4'd0);   // BCS not taken after reset

        // randomized instruction stream
        for (int k = 0; k < 300; k++) begin
            cond  = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom);
            op    = 2'($urandom);
            funct = 6'($urandom);
            if (op == 2'b00) funct = {funct[5], pick_cmd(), funct[0]};
            run_instr(cond, op, funct, 4'($urandom), 4'($urandom));
        end

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
